// File: rtl/pool2d_stream_if.sv
// Pixel-in / result-out stream bundle for pool2d_stream.
// The master side is the host; the slave side is the pooling block.
interface pool2d_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool2d_stream.sv
// Streaming 2x2 stride-2 max/average pooling over a raster-order frame.
// Even rows are pair-reduced into a half-width row buffer; odd rows close each window.
module pool2d_stream #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IMG_W      = 28,
   parameter int unsigned IMG_H      = 28
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   mode,
   pool2d_stream_if.slave         bus,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned ColW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int unsigned RowW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int unsigned BufN    = IMG_W / 2;
   localparam int unsigned BufIdxW = (BufN > 1) ? $clog2(BufN) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   state_e                  state_q, state_d;
   logic [ColW-1:0]         col_q, col_d;
   logic [RowW-1:0]         row_q, row_d;
   logic                    mode_q, mode_d;
   logic [DATA_WIDTH-1:0]   hold_q, hold_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_last_q, out_last_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   // Entry holds either a pair max (MSB zero) or a pair sum.
   logic [DATA_WIDTH:0]     rowbuf_q [BufN];
   logic                    buf_we;
   logic [BufIdxW-1:0]      buf_idx;
   logic [DATA_WIDTH:0]     buf_rd;

   logic                    in_ready;
   logic                    accept;
   logic                    col_last;
   logic                    row_last;
   logic [DATA_WIDTH-1:0]   pair_max;
   logic [DATA_WIDTH:0]     pair_sum;
   logic [DATA_WIDTH:0]     pair_red;
   logic [DATA_WIDTH-1:0]   win_max;
   logic [DATA_WIDTH+1:0]   win_sum;
   logic [DATA_WIDTH-1:0]   result;

   assign in_ready = (state_q == StRun) && !(out_valid_q && !bus.out_ready);
   assign accept   = in_ready && bus.in_valid;
   assign col_last = (col_q == ColW'(IMG_W - 1));
   assign row_last = (row_q == RowW'(IMG_H - 1));

   assign buf_idx  = BufIdxW'(col_q >> 1);
   assign buf_rd   = rowbuf_q[buf_idx];

   always_comb begin
      pair_max = (hold_q > bus.in_data) ? hold_q : bus.in_data;
      pair_sum = {1'b0, hold_q} + {1'b0, bus.in_data};
      pair_red = mode_q ? pair_sum : {1'b0, pair_max};
      win_max  = (buf_rd[DATA_WIDTH-1:0] > pair_max) ? buf_rd[DATA_WIDTH-1:0] : pair_max;
      win_sum  = {1'b0, buf_rd} + {1'b0, pair_sum};
      result   = mode_q ? win_sum[DATA_WIDTH+1:2] : win_max;
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      mode_d      = mode_q;
      hold_d      = hold_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      buf_we      = 1'b0;

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               mode_d  = mode;
               col_d   = '0;
               row_d   = '0;
            end
         end
         StRun: begin
            if (accept) begin
               if (col_last) begin
                  col_d = '0;
                  row_d = row_last ? '0 : row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end

               if (!col_q[0]) begin
                  hold_d = bus.in_data;
               end else if (!row_q[0]) begin
                  buf_we = 1'b1;
               end else begin
                  out_valid_d = 1'b1;
                  out_data_d  = result;
                  out_last_d  = col_last && row_last;
               end

               if (col_last && row_last) begin
                  state_d = StFlush;
               end
            end
         end
         StFlush: begin
            if (out_valid_q && bus.out_ready) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d == StRun) || (state_d == StFlush);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         col_q       <= '0;
         row_q       <= '0;
         mode_q      <= 1'b0;
         hold_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         mode_q      <= mode_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // No reset: every entry is written by the even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         rowbuf_q[buf_idx] <= pair_red;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream on a 4x4 frame of 8-bit pixels.
module tb_pool2d_stream;

   logic clk;
   logic reset;
   logic start;
   logic mode;
   logic busy;
   logic done;

   pool2d_stream_if #(.DATA_WIDTH(8)) bus_if ();

   pool2d_stream #(
      .DATA_WIDTH (8),
      .IMG_W      (4),
      .IMG_H      (4)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mode  (mode),
      .bus   (bus_if.slave),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int res_q[$];
   bit lst_q[$];
   int done_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Capture handshaken results and done pulses, after any same-edge input updates.
   always @(negedge clk) begin
      #2;
      if (bus_if.out_valid && bus_if.out_ready) begin
         res_q.push_back(int'(bus_if.out_data));
         lst_q.push_back(bus_if.out_last);
      end
      if (done) done_cnt++;
   end

   task automatic feed_frame(input logic m, input bit all_max, input int npix,
                             input bit inject_start);
      int t;
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(negedge clk);
      start = 1'b0;
      mode  = 1'b0;
      for (int i = 0; i < npix; i++) begin
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = all_max ? 8'd255 : 8'(i);
         if (inject_start && i == 6) begin
            start = 1'b1;
            mode  = 1'b1;
         end
         if (inject_start && i == 10) check("busy_mid", {31'd0, busy}, 32'd1);
         #1;
         t = 0;
         while (!bus_if.in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
         end
         if (t >= 50) check("in_ready_timeout", 32'(t), 32'd0);
         @(negedge clk);
         start = 1'b0;
         mode  = 1'b0;
      end
      bus_if.in_valid = 1'b0;
      bus_if.in_data  = 8'd0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (done_cnt == 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      #3;
   endtask

   task automatic check_frame(input string tag, input int e0, input int e1, input int e2,
                              input int e3);
      int exp_v[4];
      exp_v = '{e0, e1, e2, e3};
      check({tag, "_count"}, 32'(res_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_data%0d", tag, i),
               (i < res_q.size()) ? 32'(res_q[i]) : 32'hFFFF_FFFF, 32'(exp_v[i]));
         check($sformatf("%s_last%0d", tag, i),
               (i < lst_q.size()) ? {31'd0, lst_q[i]} : 32'hFFFF_FFFF,
               (i == 3) ? 32'd1 : 32'd0);
      end
      check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic clear_log();
      res_q.delete();
      lst_q.delete();
      done_cnt = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},  {31'd0, bus_if.in_ready},  32'd0);
      check({tag, "_out_valid"}, {31'd0, bus_if.out_valid}, 32'd0);
      check({tag, "_out_data"},  {24'd0, bus_if.out_data},  32'd0);
      check({tag, "_out_last"},  {31'd0, bus_if.out_last},  32'd0);
      check({tag, "_busy"},      {31'd0, busy},             32'd0);
      check({tag, "_done"},      {31'd0, done},             32'd0);
   endtask

   initial begin
      reset            = 1'b1;
      start            = 1'b0;
      mode             = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = 8'd0;
      bus_if.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;
      @(negedge clk);
      check("idle_in_ready", {31'd0, bus_if.in_ready}, 32'd0);

      clear_log();
      feed_frame(1'b0, 1'b0, 16, 1'b0);
      wait_done();
      check_frame("max", 5, 7, 13, 15);

      clear_log();
      feed_frame(1'b1, 1'b0, 16, 1'b0);
      wait_done();
      check_frame("avg", 2, 4, 10, 12);

      clear_log();
      feed_frame(1'b1, 1'b1, 16, 1'b0);
      wait_done();
      check_frame("avg255", 255, 255, 255, 255);

      // Downstream stall of 5 cycles right after the first result.
      clear_log();
      fork
         feed_frame(1'b0, 1'b0, 16, 1'b0);
         begin
            int t = 0;
            @(negedge clk);
            while (!bus_if.out_valid && t < 100) begin
               @(negedge clk);
               t++;
            end
            bus_if.out_ready = 1'b0;
            repeat (5) begin
               #1;
               check("stall_out_data",  {24'd0, bus_if.out_data},  32'd5);
               check("stall_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
               check("stall_in_ready",  {31'd0, bus_if.in_ready},  32'd0);
               @(negedge clk);
            end
            bus_if.out_ready = 1'b1;
         end
      join
      wait_done();
      check_frame("stall", 5, 7, 13, 15);

      // Reset mid-frame, then a clean max frame.
      feed_frame(1'b0, 1'b0, 6, 1'b0);
      #1;
      reset = 1'b1;
      #2;
      check_reset_vals("midrst");
      @(negedge clk);
      reset = 1'b0;
      clear_log();
      feed_frame(1'b0, 1'b0, 16, 1'b0);
      wait_done();
      check_frame("postrst", 5, 7, 13, 15);

      // start with mode=1 mid-frame must not disturb a max frame.
      clear_log();
      feed_frame(1'b0, 1'b0, 16, 1'b1);
      wait_done();
      check_frame("midstart", 5, 7, 13, 15);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width, unsigned.
REQ-002 SHALL have parameter IMG_W, default 28: input row length in pixels; even, >=2.
REQ-003 SHALL have parameter IMG_H, default 28: input rows per frame; even, >=2.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle frame start request.
REQ-007 SHALL have port mode  input  1  0 = max pool, 1 = average pool; sampled only with an accepted start.
REQ-008 SHALL have port in_valid  input  1  in_data holds a valid pixel.
REQ-009 SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-010 SHALL have port in_data  input  DATA_WIDTH  pixel, raster order (row-major, column 0 first).
REQ-011 SHALL have port out_valid  output  1  out_data holds a pooled result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_data  output  DATA_WIDTH  pooled value.
REQ-014 SHALL have port out_last  output  1  qualifies the final result of the frame.
REQ-015 SHALL have port busy  output  1  high in RUN and FLUSH.
REQ-016 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-017 SHALL implement a 2x2 window, stride 2, giving (IMG_W/2)x(IMG_H/2) results per frame, emitted in raster order.
REQ-018 SHALL implement FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start, latching mode and clearing the row/column counters.
REQ-019 SHALL ignore start in RUN, FLUSH and DONE; the latched mode SHALL NOT change mid-frame.
REQ-020 SHALL hold in_ready low in IDLE, FLUSH and DONE; in RUN, in_ready = !(out_valid && !out_ready).
REQ-021 SHALL count an input pixel only on in_valid && in_ready; the column counter wraps at IMG_W-1 and increments the row counter.
REQ-022 Even rows: at each odd column SHALL store the pair reduction of columns c-1 and c in a row buffer of IMG_W/2 entries (max: DATA_WIDTH bits; avg: DATA_WIDTH+1-bit sum).
REQ-023 Odd rows: at each even column SHALL hold the pixel in a register; at each odd column SHALL combine it with the held pixel and buffer entry c/2.
REQ-024 Max mode SHALL output the unsigned maximum of the 4 pixels; avg mode SHALL output floor(sum/4), with the sum kept at DATA_WIDTH+2 bits (no overflow, no rounding).
REQ-025 out_valid and out_data SHALL be registered and asserted the cycle after the window-closing pixel is accepted.
REQ-026 out_valid/out_data/out_last SHALL stay stable while out_valid && !out_ready; out_valid SHALL clear after out_ready unless a new result is loaded in the same cycle.
REQ-027 out_last SHALL be high with the result of window (IMG_H/2-1, IMG_W/2-1) and low otherwise.
REQ-028 RUN->FLUSH on acceptance of pixel (IMG_H-1, IMG_W-1); FLUSH->DONE once the last result handshakes; DONE->IDLE after one cycle, with done high only in DONE.
REQ-029 SHALL accept at most one pixel per cycle and sustain one pixel per cycle when out_ready is held high.

Reset
REQ-030 On reset assertion, SHALL asynchronously force: state IDLE, counters 0, in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0, latched mode 0.
REQ-031 Row buffer contents SHALL need no reset; a frame SHALL never read an entry its own even row has not written.
REQ-032 Reset mid-frame SHALL discard the partial frame; the next start SHALL produce a correct frame.

Verification (IMG_W=4, IMG_H=4, DATA_WIDTH=8)
REQ-033 Max, pixels 0..15 streamed back-to-back, out_ready=1 -> outputs 5,7,13,15; out_last with 15; one done pulse.
REQ-034 Avg, same stimulus -> outputs 2,4,10,12.
REQ-035 Avg, all pixels 255 -> four outputs of 255 (no overflow wrap).
REQ-036 Max, out_ready low for 5 cycles after the first result -> out_data held at 5, in_ready low, no lost or duplicated results; sequence still 5,7,13,15.
REQ-037 Reset pulsed after 6 accepted pixels -> all outputs at reset values; new max frame of 0..15 -> 5,7,13,15.
REQ-038 start with mode=1 asserted mid-frame in a max frame -> ignored; max results produced, busy stays high until done.
